// File: rtl/example_core_stream_packer_if.sv
// Stream packer bundle: narrow beat input, packed word output with FIFO status.
// The DUT takes the slave modport; the producer/consumer side takes master.
interface example_core_stream_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int FIFO_DEPTH = 4
);
    logic                           valid_in_i;
    logic [DATA_WIDTH-1:0]          data_in_i;
    logic                           flush_i;
    logic [DATA_WIDTH*PACK-1:0]     word_o;
    logic                           word_valid_o;
    logic                           word_ready_i;
    logic [$clog2(FIFO_DEPTH):0]    level_o;
    logic                           overflow_o;
    logic                           clear_ovf_i;

    modport slave (
        input  valid_in_i, data_in_i, flush_i, word_ready_i, clear_ovf_i,
        output word_o, word_valid_o, level_o, overflow_o
    );

    modport master (
        output valid_in_i, data_in_i, flush_i, word_ready_i, clear_ovf_i,
        input  word_o, word_valid_o, level_o, overflow_o
    );
endinterface

// File: rtl/example_core_stream_packer.sv
// Packs PACK narrow beats little-endian into one word and queues it in a small FIFO.
// Optional macro EXAMPLE_CORE_DROP_CNT_EN adds an 8-bit saturating dropped-word counter.
module example_core_stream_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    example_core_stream_packer_if.slave bus
`ifdef EXAMPLE_CORE_DROP_CNT_EN
    ,
    output logic [7:0] drop_cnt_o
`endif
);
    localparam int CNT_W  = $clog2(PACK);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int WORD_W = DATA_WIDTH * PACK;

    logic [CNT_W-1:0]                   cnt_reg, cnt_next;
    logic [PACK-2:0][DATA_WIDTH-1:0]    lanes_reg;
    logic [WORD_W-1:0]                  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]                   wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [LVL_W-1:0]                   level_reg, level_next;
    logic [WORD_W-1:0]                  word_reg, word_next, new_word;
    logic                               ovf_reg;

    logic beat, last_beat, full, pop, push, drop;

    always_comb begin
        beat      = bus.valid_in_i && !bus.flush_i;
        last_beat = beat && (cnt_reg == CNT_W'(PACK - 1));
        full      = (level_reg == LVL_W'(FIFO_DEPTH));
        pop       = (level_reg != '0) && bus.word_ready_i;
        push      = last_beat && (!full || pop);
        drop      = last_beat && full && !pop;
        // The final lane is never stored: it goes straight from the input into the word.
        new_word  = {bus.data_in_i, lanes_reg};
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (bus.flush_i)
            cnt_next = '0;
        else if (beat)
            cnt_next = last_beat ? '0 : cnt_reg + CNT_W'(1);
    end

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
        rd_ptr_next = pop ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
        // A word written this edge that becomes the new head is bypassed past the array.
        word_next = (push && (wr_ptr_reg == rd_ptr_next)) ? new_word : mem[rd_ptr_next];
    end

    for (genvar gi = 0; gi < PACK - 1; gi++) begin : g_lane
        always_ff @(posedge clk_i) begin
            if (rst_i || bus.flush_i)
                lanes_reg[gi] <= '0;
            else if (beat && (cnt_reg == CNT_W'(gi)))
                lanes_reg[gi] <= bus.data_in_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr_reg] <= new_word;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            word_reg   <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            wr_ptr_reg <= push ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            word_reg   <= word_next;
            if (drop)
                ovf_reg <= 1'b1;
            else if (bus.clear_ovf_i)
                ovf_reg <= 1'b0;
        end
    end

`ifdef EXAMPLE_CORE_DROP_CNT_EN
    logic [7:0] drop_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            drop_cnt_reg <= '0;
        else if (drop)
            drop_cnt_reg <= bus.clear_ovf_i ? 8'd1 :
                            (drop_cnt_reg == 8'hFF) ? 8'hFF : drop_cnt_reg + 8'd1;
        else if (bus.clear_ovf_i)
            drop_cnt_reg <= '0;
    end

    assign drop_cnt_o = drop_cnt_reg;
`endif

    assign bus.word_o       = word_reg;
    assign bus.word_valid_o = (level_reg != '0);
    assign bus.level_o      = level_reg;
    assign bus.overflow_o   = ovf_reg;
endmodule

// File: tb/tb_example_core_stream_packer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_example_core_stream_packer;
    localparam int DW = 8;
    localparam int PK = 4;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    example_core_stream_packer_if #(.DATA_WIDTH(DW), .PACK(PK), .FIFO_DEPTH(FD)) bus ();

`ifdef EXAMPLE_CORE_DROP_CNT_EN
    logic [7:0] drop_cnt;
    example_core_stream_packer #(.DATA_WIDTH(DW), .PACK(PK), .FIFO_DEPTH(FD)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus), .drop_cnt_o(drop_cnt));
`else
    example_core_stream_packer #(.DATA_WIDTH(DW), .PACK(PK), .FIFO_DEPTH(FD)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus));
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: pending beats, queued words, sticky flag, drop count
    logic [DW-1:0]    m_part[$];
    logic [DW*PK-1:0] m_fifo[$];
    logic             m_ovf = 1'b0;
    int               m_drop = 0;

    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic f,
                         input logic r, input logic c, input logic rs);
        bit do_pop, have_word, full_before, dropped;
        logic [DW*PK-1:0] w;
        bus.valid_in_i   = v;
        bus.data_in_i    = d;
        bus.flush_i      = f;
        bus.word_ready_i = r;
        bus.clear_ovf_i  = c;
        rst              = rs;
        @(posedge clk);
        w = '0;
        if (rs) begin
            m_part.delete();
            m_fifo.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            full_before = (m_fifo.size() == FD);
            do_pop      = (m_fifo.size() > 0) && r;
            have_word   = 1'b0;
            if (f)
                m_part.delete();
            else if (v) begin
                m_part.push_back(d);
                if (m_part.size() == PK) begin
                    for (int k = 0; k < PK; k++) w[k*DW +: DW] = m_part[k];
                    m_part.delete();
                    have_word = 1'b1;
                end
            end
            if (do_pop) m_fifo.delete(0);
            dropped = have_word && full_before && !do_pop;
            if (have_word && !dropped) m_fifo.push_back(w);
            if (dropped) begin
                m_ovf  = 1'b1;
                m_drop = c ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
            end else if (c) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
        end
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic r);
        cycle(1'b1, d, 1'b0, r, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        cycle(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1);
        checks++; if (bus.level_o !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", bus.level_o); end
        checks++; if (bus.word_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.word_valid_o); end
        checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.overflow_o); end
        checks++; if (bus.word_o !== 32'h0) begin errors++; $display("FAIL reset_word: got %h expected 0", bus.word_o); end
`ifdef EXAMPLE_CORE_DROP_CNT_EN
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
`endif
    endtask

    task automatic test_basic();
        do_reset();
        beat(8'h11, 1'b1);
        beat(8'h22, 1'b1);
        beat(8'h33, 1'b1);
        checks++; if (bus.word_valid_o !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", bus.word_valid_o); end
        beat(8'h44, 1'b1);
        checks++; if (bus.word_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", bus.word_valid_o); end
        checks++; if (bus.word_o !== 32'h44332211) begin errors++; $display("FAIL basic_word: got %h expected 44332211", bus.word_o); end
        checks++; if (bus.level_o !== 3'd1) begin errors++; $display("FAIL basic_level1: got %0d expected 1", bus.level_o); end
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.level_o !== 3'd0 || bus.word_valid_o !== 1'b0) begin errors++; $display("FAIL basic_drain: got level %0d valid %b expected 0 0", bus.level_o, bus.word_valid_o); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_w;
        do_reset();
        for (int i = 0; i < 20; i++) beat(8'(i), 1'b0);
        checks++; if (bus.level_o !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d expected 4", bus.level_o); end
        checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", bus.overflow_o); end
`ifdef EXAMPLE_CORE_DROP_CNT_EN
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL ovf_drop_cnt: got %0d expected 1", drop_cnt); end
`endif
        for (int k = 0; k < 4; k++) begin
            exp_w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            checks++; if (bus.word_o !== exp_w || bus.word_valid_o !== 1'b1) begin errors++; $display("FAIL ovf_pop_word%0d: got %h valid %b expected %h", k, bus.word_o, bus.word_valid_o, exp_w); end
            cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        checks++; if (bus.level_o !== 3'd0) begin errors++; $display("FAIL ovf_drained: got %0d expected 0", bus.level_o); end
        checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", bus.overflow_o); end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", bus.overflow_o); end
    endtask

    task automatic test_full_pushpop();
        logic [31:0] exp_w;
        do_reset();
        for (int i = 0; i < 19; i++) beat(8'(i), 1'b0);
        checks++; if (bus.level_o !== 3'd4) begin errors++; $display("FAIL fpp_full: got %0d expected 4", bus.level_o); end
        beat(8'h13, 1'b1);
        checks++; if (bus.level_o !== 3'd4) begin errors++; $display("FAIL fpp_level: got %0d expected 4", bus.level_o); end
        checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b expected 0", bus.overflow_o); end
        for (int k = 1; k < 5; k++) begin
            exp_w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            checks++; if (bus.word_o !== exp_w) begin errors++; $display("FAIL fpp_word%0d: got %h expected %h", k, bus.word_o, exp_w); end
            cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_flush();
        do_reset();
        beat(8'hAA, 1'b0);
        beat(8'hBB, 1'b0);
        cycle(1'b1, 8'hCC, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) beat(8'(i), 1'b0);
        checks++; if (bus.level_o !== 3'd1) begin errors++; $display("FAIL flush_level: got %0d expected 1", bus.level_o); end
        checks++; if (bus.word_o !== 32'h04030201) begin errors++; $display("FAIL flush_word: got %h expected 04030201", bus.word_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 22; i++) beat(8'(i), 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.level_o !== 3'd0 || bus.word_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_fifo: got level %0d valid %b expected 0 0", bus.level_o, bus.word_valid_o); end
        checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL rstmid_ovf: got %b expected 0", bus.overflow_o); end
        for (int i = 0; i < 4; i++) beat(8'(8'h5A + i), 1'b0);
        checks++; if (bus.word_o !== 32'h5D5C5B5A || bus.level_o !== 3'd1) begin errors++; $display("FAIL rstmid_word: got %h level %0d expected 5d5c5b5a 1", bus.word_o, bus.level_o); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
            checks++; if (bus.level_o !== 3'(m_fifo.size())) begin errors++; $display("FAIL rnd_level@%0d: got %0d expected %0d", n, bus.level_o, m_fifo.size()); end
            checks++; if (bus.word_valid_o !== (m_fifo.size() > 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", n, bus.word_valid_o, m_fifo.size() > 0); end
            checks++; if (bus.overflow_o !== m_ovf) begin errors++; $display("FAIL rnd_ovf@%0d: got %b expected %b", n, bus.overflow_o, m_ovf); end
            if (m_fifo.size() > 0) begin
                checks++; if (bus.word_o !== m_fifo[0]) begin errors++; $display("FAIL rnd_word@%0d: got %h expected %h", n, bus.word_o, m_fifo[0]); end
            end
`ifdef EXAMPLE_CORE_DROP_CNT_EN
            checks++; if (drop_cnt !== 8'(m_drop)) begin errors++; $display("FAIL rnd_drop_cnt@%0d: got %0d expected %0d", n, drop_cnt, m_drop); end
`endif
        end
    endtask

`ifdef EXAMPLE_CORE_DROP_CNT_EN
    task automatic test_drop_cnt();
        do_reset();
        for (int i = 0; i < 16; i++) beat(8'(i), 1'b0);
        for (int i = 0; i < 300 * PK; i++) beat(8'(i), 1'b0);
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL dropcnt_sat: got %0d expected 255", drop_cnt); end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (drop_cnt !== 8'd0 || bus.overflow_o !== 1'b0) begin errors++; $display("FAIL dropcnt_clear: got cnt %0d ovf %b expected 0 0", drop_cnt, bus.overflow_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pushpop();
        test_flush();
        test_reset_mid();
        test_random();
`ifdef EXAMPLE_CORE_DROP_CNT_EN
        test_drop_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
